gray_to_bcd_converter: RTL and testbench

Upstream stage of the two-digit 7-segment display driver. Synchronizes and debounces the Gray-coded switch word, converts it to binary, and runs a sequential double-dabble (shift-add-3) conversion. Delivers a stable packed two-digit BCD word, tens in [7:4] and units in [3:0], that feeds the display driver's `bcd_i` directly.

---
 rtl/gray_to_bcd_converter_pkg.sv | 19 +
 rtl/gray_to_bcd_converter_if.sv | 18 +
 rtl/gray_to_bcd_converter_debouncer.sv | 57 +++++
 rtl/gray_to_bcd_converter.sv | 116 +++++++++++
 tb/tb_gray_to_bcd_converter.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_to_bcd_converter_pkg.sv
// Shared definitions for the Gray-switch to two-digit BCD front end:
// FSM encoding, BCD field width and the double-dabble nibble correction.
package gray_to_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_WIDTH   = 8;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // A nibble of 5 or more would overflow past 9 after the next doubling.
  function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
    return (nib >= ADD3_THRESH) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/gray_to_bcd_converter_if.sv
// Switch-word input and converted-result outputs of the BCD front end.
// The converter is the slave side; whoever drives the switches is the master.
interface gray_to_bcd_converter_if
  import gray_to_bcd_converter_pkg::*;
#(
  parameter int GRAY_WIDTH = 4
) ();

  logic [GRAY_WIDTH-1:0] gray_i;
  logic [BCD_WIDTH-1:0]  bcd_o;
  logic [GRAY_WIDTH-1:0] bin_o;
  logic                  valid_o;
  logic                  busy_o;

  modport master (output gray_i, input bcd_o, bin_o, valid_o, busy_o);
  modport slave  (input gray_i, output bcd_o, bin_o, valid_o, busy_o);

endinterface

// File: rtl/gray_to_bcd_converter_debouncer.sv
// Two-flop synchronizer plus debounce: the switch word is accepted only
// after it has held the same value for DEBOUNCE_CYCLES clocks.
module gray_input_debouncer
  import gray_to_bcd_converter_pkg::*;
#(
  parameter int GRAY_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [GRAY_WIDTH-1:0] gray_i,
  output logic [GRAY_WIDTH-1:0] gray_stable_o
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [GRAY_WIDTH-1:0] sync1_q, sync1_d;
  logic [GRAY_WIDTH-1:0] sync2_q, sync2_d;
  logic [GRAY_WIDTH-1:0] prev_q, prev_d;
  logic [GRAY_WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    sync1_d  = gray_i;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stable_d = sync2_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign gray_stable_o = stable_q;

endmodule

// File: rtl/gray_to_bcd_converter.sv
// Debounced Gray switch word -> binary -> sequential double-dabble BCD.
// Results are published only from DONE so the display never sees partial digits.
module gray_to_bcd_converter
  import gray_to_bcd_converter_pkg::*;
#(
  parameter int GRAY_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  gray_to_bcd_converter_if.slave  bus
);

  localparam int                SR_W      = BCD_WIDTH + GRAY_WIDTH;
  localparam int                ITER_W    = $clog2(GRAY_WIDTH + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(GRAY_WIDTH - 1);

  function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [GRAY_WIDTH-1:0] gray_stable;

  state_e                state_q, state_d;
  logic [GRAY_WIDTH-1:0] gray_last_q, gray_last_d;
  logic [GRAY_WIDTH-1:0] bin_hold_q, bin_hold_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [BCD_WIDTH-1:0]  bcd_q, bcd_d;
  logic [GRAY_WIDTH-1:0] bin_q, bin_d;
  logic                  valid_q, valid_d;
  logic [SR_W-1:0]       sr_adj;

  gray_input_debouncer #(
    .GRAY_WIDTH      (GRAY_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .gray_i        (bus.gray_i),
    .gray_stable_o (gray_stable)
  );

  always_comb begin
    state_d     = state_q;
    gray_last_d = gray_last_q;
    bin_hold_d  = bin_hold_q;
    sr_d        = sr_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    valid_d     = 1'b0;
    sr_adj      = sr_q;
    case (state_q)
      ST_IDLE: begin
        if (gray_stable != gray_last_q) begin
          gray_last_d = gray_stable;
          bin_hold_d  = gray2bin(gray_stable);
          sr_d        = {{BCD_WIDTH{1'b0}}, gray2bin(gray_stable)};
          iter_d      = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Correct both digits first, then double the whole {BCD, binary} word.
        sr_adj[SR_W-1 -: 4] = add3_adjust(sr_q[SR_W-1 -: 4]);
        sr_adj[SR_W-5 -: 4] = add3_adjust(sr_q[SR_W-5 -: 4]);
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = sr_q[SR_W-1 -: BCD_WIDTH];
        bin_d   = bin_hold_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      gray_last_q <= '0;
      bin_hold_q  <= '0;
      sr_q        <= '0;
      iter_q      <= '0;
      bcd_q       <= '0;
      bin_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gray_last_q <= gray_last_d;
      bin_hold_q  <= bin_hold_d;
      sr_q        <= sr_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.bcd_o   = bcd_q;
  assign bus.bin_o   = bin_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray_to_bcd_converter.sv
// Bench for gray_to_bcd_converter with a short debounce window: vector table,
// hand-written multi-cycle corner cases and random stimulus against a model.
module tb_gray_to_bcd_converter;

  localparam int GW = 4;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_to_bcd_converter_if #(.GRAY_WIDTH(GW)) bus ();

  gray_to_bcd_converter #(
    .GRAY_WIDTH      (GW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;
  int pulses = 0;

  logic       prev_valid = 1'b0;
  logic       prev_rst   = 1'b0;
  logic [7:0] prev_bcd   = 8'h00;

  typedef struct {
    logic [3:0] gray;
    logic [7:0] bcd;
    logic [3:0] bin;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: binary is the XOR of all right shifts of the Gray word;
  // BCD is just the decimal digits of that number.
  function automatic int model_bin(input int g);
    int b = g;
    for (int s = 1; s < GW; s++) b ^= (g >> s);
    return b;
  endfunction

  function automatic int model_bcd(input int b);
    return ((b / 10) * 16) + (b % 10);
  endfunction

  // Pulse counter, one-cycle width check, and outputs-only-move-on-valid check.
  always @(negedge clk) begin
    if (rst_n && prev_rst) begin
      if (bus.valid_o) begin
        pulses++;
        check("valid_width", int'(prev_valid), 0);
      end else begin
        check("bcd_hold", int'(bus.bcd_o), int'(prev_bcd));
      end
    end
    prev_valid = bus.valid_o;
    prev_bcd   = bus.bcd_o;
    prev_rst   = rst_n;
  end

  task automatic wait_pulse(input string name, input int budget, output int lat);
    int start;
    start = pulses;
    lat   = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      #1;
      if (pulses != start) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      fails++;
      $display("FAIL %s: no valid_o within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_busy(input string name, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.busy_o) begin
        seen = 1;
        break;
      end
    end
    check({name, "_busy_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    int lat;
    int busy_cnt;
    int last_g;
    int g;

    vecs[0] = '{gray: 4'b1000, bcd: 8'h15, bin: 4'd15};
    vecs[1] = '{gray: 4'b0111, bcd: 8'h05, bin: 4'd5};
    vecs[2] = '{gray: 4'b1101, bcd: 8'h09, bin: 4'd9};
    vecs[3] = '{gray: 4'b1010, bcd: 8'h12, bin: 4'd12};
    vecs[4] = '{gray: 4'b0110, bcd: 8'h04, bin: 4'd4};

    rst_n      = 1'b0;
    bus.gray_i = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_bcd", int'(bus.bcd_o), 8'h00);
    check("rst_bin", int'(bus.bin_o), 0);
    check("rst_valid", int'(bus.valid_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    rst_n = 1'b1;

    // Input held at the reset value: nothing to convert.
    start    = pulses;
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
    end
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_pulses", pulses - start, 0);
    check("idle_bcd", int'(bus.bcd_o), 8'h00);

    for (int i = 0; i < 5; i++) begin
      start      = pulses;
      bus.gray_i = vecs[i].gray;
      wait_pulse($sformatf("vec%0d_pulse", i), 24, lat);
      if (i == 0) begin
        checks++;
        if (lat < 11 || lat > 13) begin
          fails++;
          $display("FAIL first_latency: got %0d cycles expected 11..13", lat);
        end
      end
      repeat (8) @(negedge clk);
      check($sformatf("vec%0d_pulses", i), pulses - start, 1);
      check($sformatf("vec%0d_bcd", i), int'(bus.bcd_o), int'(vecs[i].bcd));
      check($sformatf("vec%0d_bin", i), int'(bus.bin_o), int'(vecs[i].bin));
    end

    // Bouncing faster than the debounce window is never accepted.
    start = pulses;
    for (int c = 0; c < 25; c++) begin
      bus.gray_i = (c % 2 == 1) ? 4'b0011 : 4'b0001;
      repeat (2) @(negedge clk);
    end
    check("bounce_pulses", pulses - start, 0);
    check("bounce_bcd", int'(bus.bcd_o), 8'h04);
    bus.gray_i = 4'b0011;
    wait_pulse("settle_pulse", 24, lat);
    check("settle_bcd", int'(bus.bcd_o), 8'h02);

    // New input while a conversion is in flight.
    repeat (8) @(negedge clk);
    start      = pulses;
    bus.gray_i = 4'b1000;
    wait_busy("inflight", 30);
    bus.gray_i = 4'b0110;
    wait_pulse("inflight_first", 24, lat);
    check("inflight_first_bcd", int'(bus.bcd_o), 8'h15);
    wait_pulse("inflight_second", 24, lat);
    check("inflight_second_bcd", int'(bus.bcd_o), 8'h04);
    repeat (10) @(negedge clk);
    check("inflight_pulses", pulses - start, 2);

    // Reset in the middle of SHIFT.
    bus.gray_i = 4'b1000;
    wait_busy("midrst", 30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(bus.busy_o), 0);
    check("midrst_bcd", int'(bus.bcd_o), 8'h00);
    check("midrst_bin", int'(bus.bin_o), 0);
    check("midrst_valid", int'(bus.valid_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse("postrst_pulse", 30, lat);
    check("postrst_bcd", int'(bus.bcd_o), 8'h15);
    check("postrst_bin", int'(bus.bin_o), 15);
    repeat (8) @(negedge clk);

    // Random values, some preceded by a short glitch, against the model.
    last_g = 4'b1000;
    for (int r = 0; r < 30; r++) begin
      g = int'($urandom_range(0, 15));
      start = pulses;
      if ($urandom_range(0, 1) == 1) begin
        bus.gray_i = 4'($urandom_range(0, 15));
        repeat (2) @(negedge clk);
      end
      bus.gray_i = 4'(g);
      repeat (22) @(negedge clk);
      check($sformatf("rnd%0d_pulses", r), pulses - start, (g != last_g) ? 1 : 0);
      last_g = g;
      check($sformatf("rnd%0d_bcd", r), int'(bus.bcd_o), model_bcd(model_bin(last_g)));
      check($sformatf("rnd%0d_bin", r), int'(bus.bin_o), model_bin(last_g));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
